seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor that replaces wide flat ripple adders on non-critical paths in the FP datapath, such as the 48-bit mantissa product sum and the exponent arithmetic.
- Each clock it processes one CHUNK-bit slice, LSB slice first, and registers the carry between slices. This keeps the combinational depth at CHUNK full-adder stages.
- A start/busy/done handshake sequences it under the FP unit controller.

---
 rtl/seq_chunk_adder_if.sv | 26 ++
 rtl/seq_chunk_adder.sv | 119 +++++++++++
 tb/tb_seq_chunk_adder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle and start/busy/done handshake for seq_chunk_adder.
// The master side (FP unit controller) issues operands; the slave side is the adder.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 48
) ();
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             ovf;

    modport master (
        output start, in1, in2, cin, sub,
        input  busy, done, S, Cout, ovf
    );

    modport slave (
        input  start, in1, in2, cin, sub,
        output busy, done, S, Cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a flop so the combinational depth stays at
// CHUNK full-adder stages. Subtraction is A + ~B + 1 (B inverted at accept time).
module seq_chunk_adder #(
    parameter int WIDTH = 48,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_chunk_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [31:0]      shamt;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sum_sl;
    logic             msb_cin;

    // One CHUNK-bit ripple slice; the top bit of the result is the slice carry-out.
    function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             c);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    endfunction

    // Slice datapath plus the IDLE/RUN sequencing and result/flag updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        shamt   = 32'(idx_q) * 32'(CHUNK);
        a_sl    = CHUNK'(a_q >> shamt);
        b_sl    = CHUNK'(b_q >> shamt);
        sum_sl  = slice_add(a_sl, b_sl, carry_q);
        // Carry into the top bit of the slice, recovered from sum = a ^ b ^ cin.
        msb_cin = sum_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in1;
                    b_d     = bus.sub ? ~bus.in2 : bus.in2;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = (s_q & ~(SLICE_MASK << shamt))
                        | (WIDTH'(sum_sl[CHUNK-1:0]) << shamt);
                carry_d = sum_sl[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    cout_d  = sum_sl[CHUNK];
                    ovf_d   = msb_cin ^ sum_sl[CHUNK];
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, carry and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: default 48/8 instance plus 48/48 and 10/5
// instances for the parameter corners.
module tb_seq_chunk_adder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_chunk_adder_if #(.WIDTH(48)) if0 ();
    seq_chunk_adder_if #(.WIDTH(48)) if1 ();
    seq_chunk_adder_if #(.WIDTH(10)) if2 ();

    seq_chunk_adder #(.WIDTH(48), .CHUNK(8))  u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_chunk_adder #(.WIDTH(48), .CHUNK(48)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_chunk_adder #(.WIDTH(10), .CHUNK(5))  u2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Default instance: one operation, then latency, busy span, results, done width.
    task automatic run48(input string tag, input logic [47:0] a, input logic [47:0] b,
                         input logic ci, input logic sb,
                         input logic [47:0] es, input logic ec, input logic ev);
        int lat;
        int bcnt;
        @(negedge clk);
        if0.in1 = a; if0.in2 = b; if0.cin = ci; if0.sub = sb; if0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        if0.in1 = ~a; if0.in2 = ~b; if0.cin = ~ci; if0.sub = ~sb;
        lat = 0; bcnt = 0;
        while (!if0.done && lat < 20) begin
            if (if0.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".lat"},  64'(lat),  64'd6);
        check_eq({tag, ".busy"}, 64'(bcnt), 64'd6);
        check_eq({tag, ".S"},    64'(if0.S),    64'(es));
        check_eq({tag, ".Cout"}, 64'(if0.Cout), 64'(ec));
        check_eq({tag, ".ovf"},  64'(if0.ovf),  64'(ev));
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 64'(if0.done), 64'd0);
    endtask

    task automatic run_c48(input string tag, input logic [47:0] a, input logic [47:0] b,
                           input logic ci, input logic sb,
                           input logic [47:0] es, input logic ec, input logic ev);
        int lat;
        @(negedge clk);
        if1.in1 = a; if1.in2 = b; if1.cin = ci; if1.sub = sb; if1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.start = 1'b0;
        lat = 0;
        while (!if1.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".lat"},  64'(lat),       64'd1);
        check_eq({tag, ".S"},    64'(if1.S),     64'(es));
        check_eq({tag, ".Cout"}, 64'(if1.Cout),  64'(ec));
        check_eq({tag, ".ovf"},  64'(if1.ovf),   64'(ev));
    endtask

    task automatic run_w10(input string tag, input logic [9:0] a, input logic [9:0] b,
                           input logic ci, input logic sb,
                           input logic [9:0] es, input logic ec, input logic ev);
        int lat;
        @(negedge clk);
        if2.in1 = a; if2.in2 = b; if2.cin = ci; if2.sub = sb; if2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        lat = 0;
        while (!if2.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".lat"},  64'(lat),       64'd2);
        check_eq({tag, ".S"},    64'(if2.S),     64'(es));
        check_eq({tag, ".Cout"}, 64'(if2.Cout),  64'(ec));
        check_eq({tag, ".ovf"},  64'(if2.ovf),   64'(ev));
    endtask

    initial begin
        int t;
        int t1;
        int t2;
        int lat;
        int dcnt;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        if0.start = 1'b0; if0.in1 = '0; if0.in2 = '0; if0.cin = 1'b0; if0.sub = 1'b0;
        if1.start = 1'b0; if1.in1 = '0; if1.in2 = '0; if1.cin = 1'b0; if1.sub = 1'b0;
        if2.start = 1'b0; if2.in1 = '0; if2.in2 = '0; if2.cin = 1'b0; if2.sub = 1'b0;

        #2 rst = 1'b1;
        #1;
        check_eq("rst.busy", 64'(if0.busy), 64'd0);
        check_eq("rst.done", 64'(if0.done), 64'd0);
        check_eq("rst.S",    64'(if0.S),    64'd0);
        check_eq("rst.Cout", 64'(if0.Cout), 64'd0);
        check_eq("rst.ovf",  64'(if0.ovf),  64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run48("add_ff_1",   48'h0000_0000_00FF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h0000_0000_0100, 1'b0, 1'b0);
        run48("ripple",     48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 1'b1, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b0);
        run48("sovf_add",   48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1);
        run48("sub_5_7",    48'h0000_0000_0005, 48'h0000_0000_0007, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0);
        run48("sub_7_5",    48'h0000_0000_0007, 48'h0000_0000_0005, 1'b0, 1'b1, 48'h0000_0000_0002, 1'b1, 1'b0);
        run48("sovf_sub",   48'h8000_0000_0000, 48'h0000_0000_0001, 1'b0, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1);

        // Reset in the middle of a RUN, asserted between clock edges.
        @(negedge clk);
        if0.in1 = 48'h1234_5678_9ABC; if0.in2 = 48'h1111_1111_1111; if0.sub = 1'b0; if0.cin = 1'b0;
        if0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("arst.busy_before", 64'(if0.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst.busy", 64'(if0.busy), 64'd0);
        check_eq("arst.done", 64'(if0.done), 64'd0);
        check_eq("arst.S",    64'(if0.S),    64'd0);
        check_eq("arst.Cout", 64'(if0.Cout), 64'd0);
        check_eq("arst.ovf",  64'(if0.ovf),  64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (if0.done) dcnt++;
            @(negedge clk);
        end
        check_eq("arst.no_done", 64'(dcnt), 64'd0);
        run48("after_rst",  48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 1'b0, 48'h2345_6789_ABCD, 1'b0, 1'b0);

        // start held high: the second operation is taken in the done cycle.
        @(negedge clk);
        if0.in1 = 48'd1; if0.in2 = 48'd2; if0.cin = 1'b0; if0.sub = 1'b0; if0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in1 = 48'd3; if0.in2 = 48'd4;
        t = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && t < 40) begin
            if (if0.done) begin
                if (t1 < 0) begin
                    t1 = t;
                    check_eq("b2b.S1", 64'(if0.S), 64'd3);
                end else begin
                    t2 = t;
                    check_eq("b2b.S2", 64'(if0.S), 64'd7);
                    if0.start = 1'b0;
                end
            end
            @(negedge clk);
            t++;
        end
        if0.start = 1'b0;
        check_eq("b2b.gap", 64'(t2 - t1), 64'd7);
        check_eq("b2b.idle", 64'(if0.busy), 64'd0);

        // A start pulse during RUN neither disturbs the operation nor queues.
        @(negedge clk);
        if0.in1 = 48'd10; if0.in2 = 48'd20; if0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        lat = 0;
        while (!if0.done && lat < 20) begin
            if (lat == 2) begin
                if0.in1 = 48'd100; if0.in2 = 48'd200; if0.start = 1'b1;
            end else begin
                if0.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if0.start = 1'b0;
        check_eq("midstart.lat", 64'(lat),   64'd6);
        check_eq("midstart.S",   64'(if0.S), 64'd30);
        @(negedge clk);
        check_eq("midstart.no_queue", 64'(if0.busy), 64'd0);

        run_c48("c48_wrap", 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b0);
        run_c48("c48_sub",  48'h0000_0000_0005, 48'h0000_0000_0007, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0);

        run_w10("w10_wrap", 10'h3FF, 10'h001, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
        run_w10("w10_sovf", 10'h1FF, 10'h001, 1'b0, 1'b0, 10'h200, 1'b0, 1'b1);
        run_w10("w10_sub",  10'h005, 10'h007, 1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0);
        run_w10("w10_cin",  10'h155, 10'h0AB, 1'b1, 1'b0, 10'h201, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
